// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: sequences the flappy-bird height counter.
// A flap starts a rise of FLAP_STEPS inc pulses. A hover of HOVER_TICKS
// ticks follows, then a fall whose dec pulses speed up from FALL_DLY0
// ticks apart down to one tick apart. Reaching the ground or a pipe
// collision ends the game, and restart returns to IDLE.
module bird_motion_ctrl #(
  parameter int b           = 4,
  parameter int m           = 14,
  parameter int TICK_CYCLES = 4,
  parameter int FLAP_STEPS  = 3,
  parameter int HOVER_TICKS = 2,
  parameter int FALL_DLY0   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flap,
  input  logic         crash,
  input  logic         restart,
  input  logic [b-1:0] cnt,
  output logic         inc,
  output logic         dec,
  output logic         playing,
  output logic         dead
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = $clog2(FLAP_STEPS + 1);
  localparam int HW = $clog2(HOVER_TICKS + 1);
  localparam int FW = $clog2(FALL_DLY0 + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] RISE_LD  = RW'(FLAP_STEPS);
  localparam logic [HW-1:0] HOV_LD   = HW'(HOVER_TICKS);
  localparam logic [FW-1:0] FALL_LD  = FW'(FALL_DLY0);
  localparam logic [b-1:0]  CEIL     = b'(m - 1);

  typedef enum logic [2:0] {IDLE, RISE, HOVER, FALL, DEAD} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          flap_q;
  logic [RW-1:0] rise_cnt;
  logic [HW-1:0] hov_cnt;
  logic [FW-1:0] fall_dly;
  logic [FW-1:0] wait_cnt;

  logic          tick;
  logic          flap_edge;
  logic          at_ceil;
  logic          at_ground;
  logic [FW-1:0] next_dly;

  assign tick      = (presc == PRE_LAST);
  assign flap_edge = flap & ~flap_q;
  assign at_ceil   = (cnt == CEIL);
  assign at_ground = (cnt == '0);
  // Fall spacing shrinks by one tick per step but never below one tick.
  assign next_dly  = (fall_dly > FW'(1)) ? fall_dly - FW'(1) : FW'(1);

  assign playing = (state == RISE) || (state == HOVER) || (state == FALL);
  assign dead    = (state == DEAD);

  // Free-running motion tick prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                presc <= '0;
    else if (presc == PRE_LAST) presc <= '0;
    else                     presc <= presc + PW'(1);
  end

  // Previous flap level, so a held button counts as one flap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flap_q <= 1'b0;
    else      flap_q <= flap;
  end

  // Motion FSM. Per cycle: crash beats flap, flap beats the tick action.
  // inc/dec default low, so a crash also cancels a pulse from the same tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inc      <= 1'b0;
      dec      <= 1'b0;
      rise_cnt <= '0;
      hov_cnt  <= '0;
      fall_dly <= '0;
      wait_cnt <= '0;
    end else begin
      inc <= 1'b0;
      dec <= 1'b0;
      case (state)
        IDLE: begin
          if (flap_edge) begin
            state    <= RISE;
            rise_cnt <= RISE_LD;
          end
        end
        RISE: begin
          if (crash) begin
            state <= DEAD;
          end else if (flap_edge) begin
            rise_cnt <= RISE_LD;
          end else if (tick) begin
            // At the ceiling the step is consumed without a pulse.
            if (!at_ceil) inc <= 1'b1;
            rise_cnt <= rise_cnt - RW'(1);
            if (rise_cnt <= RW'(1)) begin
              state   <= HOVER;
              hov_cnt <= HOV_LD;
            end
          end
        end
        HOVER: begin
          if (crash) begin
            state <= DEAD;
          end else if (flap_edge) begin
            state    <= RISE;
            rise_cnt <= RISE_LD;
          end else if (tick) begin
            hov_cnt <= hov_cnt - HW'(1);
            if (hov_cnt <= HW'(1)) begin
              state    <= FALL;
              fall_dly <= FALL_LD;
              wait_cnt <= FALL_LD;
            end
          end
        end
        FALL: begin
          if (crash) begin
            state <= DEAD;
          end else if (flap_edge) begin
            state    <= RISE;
            rise_cnt <= RISE_LD;
          end else if (tick) begin
            if (wait_cnt <= FW'(1)) begin
              if (at_ground) begin
                state <= DEAD;
              end else begin
                dec      <= 1'b1;
                fall_dly <= next_dly;
                wait_cnt <= next_dly;
              end
            end else begin
              wait_cnt <= wait_cnt - FW'(1);
            end
          end
        end
        DEAD: begin
          if (restart) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with a behavioural mod-m height counter.
module tb_bird_motion_ctrl;
  localparam int B = 4;
  localparam int M = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flap = 1'b0, crash = 1'b0, restart = 1'b0;
  logic [B-1:0] cnt;
  logic         inc, dec, playing, dead;
  logic         ld = 1'b0;
  logic [B-1:0] ld_v = '0;

  int total = 0, bad = 0, cyc = 0;
  int inc_t[$];
  int dec_t[$];
  int both_n = 0, gap_err = 0, dead_t = -1;
  bit rec = 1'b0;

  always #5 clk = ~clk;

  bird_motion_ctrl #(
    .b(B), .m(M), .TICK_CYCLES(4), .FLAP_STEPS(3), .HOVER_TICKS(2), .FALL_DLY0(3)
  ) dut (
    .clk(clk), .rst(rst), .flap(flap), .crash(crash), .restart(restart),
    .cnt(cnt), .inc(inc), .dec(dec), .playing(playing), .dead(dead)
  );

  // Height counter wraps modulo M like the real one, so a bad inc shows up.
  always @(posedge clk) begin
    if (ld)       cnt <= ld_v;
    else if (inc) cnt <= (cnt == B'(M - 1)) ? '0 : cnt + 1'b1;
    else if (dec) cnt <= (cnt == '0) ? B'(M - 1) : cnt - 1'b1;
  end

  // Pulse recorder, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (inc) inc_t.push_back(cyc);
    if (dec) dec_t.push_back(cyc);
    if (inc && dec) both_n = both_n + 1;
    if (rec && inc_t.size() > 0 && !dead && !playing) gap_err = gap_err + 1;
    if (dead && dead_t < 0) dead_t = cyc;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    inc_t.delete();
    dec_t.delete();
    both_n = 0;
    gap_err = 0;
    dead_t = -1;
  endtask

  task automatic load(input int v);
    ld = 1'b1;
    ld_v = B'(v);
    cyc_n(1);
    ld = 1'b0;
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    cyc_n(1);
    flap = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc_n(1);
    restart = 1'b0;
  endtask

  // Wait (bounded) until n inc or dec pulses have been recorded.
  task automatic wait_pulses(input bit is_dec, input int n, input int max, input string tag);
    int k = 0;
    while (((is_dec ? dec_t.size() : inc_t.size()) < n) && k < max) begin
      cyc_n(1);
      k++;
    end
    if ((is_dec ? dec_t.size() : inc_t.size()) < n)
      chk(tag, is_dec ? dec_t.size() : inc_t.size(), n);
  endtask

  initial begin
    // 1: reset with random inputs, then a quiet idle period
    cyc_n(1);
    for (int i = 0; i < 8; i++) begin
      flap = 1'($urandom_range(0, 1));
      crash = 1'($urandom_range(0, 1));
      restart = 1'($urandom_range(0, 1));
      cyc_n(1);
      chk("rst_out", int'({inc, dec, playing, dead}), 0);
    end
    flap = 1'b0; crash = 1'b0; restart = 1'b0;
    rst = 1'b1;
    clr();
    cyc_n(100);
    chk("idle_inc", inc_t.size(), 0);
    chk("idle_dec", dec_t.size(), 0);
    chk("idle_play", int'(playing), 0);
    chk("idle_dead", int'(dead), 0);

    // 2 + 4: flap from 5, rise, hover, accelerating fall to the ground
    load(5);
    clr();
    rec = 1'b1;
    pulse_flap();
    cyc_n(1);
    chk("t2_play", int'(playing), 1);
    wait_pulses(1'b0, 3, 20, "t2_inc_tmo");
    cyc_n(2);
    chk("t2_cnt_top", int'(cnt), 8);
    if (inc_t.size() == 3) begin
      chk("t2_inc_gap0", inc_t[1] - inc_t[0], 4);
      chk("t2_inc_gap1", inc_t[2] - inc_t[1], 4);
    end
    wait_pulses(1'b1, 8, 100, "t2_dec_tmo");
    cyc_n(6);
    chk("t2_inc_n", inc_t.size(), 3);
    chk("t2_dec_n", dec_t.size(), 8);
    if (dec_t.size() == 8 && inc_t.size() == 3) begin
      chk("t2_hover_gap", dec_t[0] - inc_t[2], 20);
      chk("t2_dec_gap0", dec_t[1] - dec_t[0], 8);
      chk("t2_dec_gap1", dec_t[2] - dec_t[1], 4);
      chk("t2_dec_gap2", dec_t[3] - dec_t[2], 4);
      chk("t2_dec_gap6", dec_t[7] - dec_t[6], 4);
      chk("t4_dead_time", dead_t - dec_t[7], 4);
    end
    chk("t4_cnt", int'(cnt), 0);
    chk("t4_dead", int'(dead), 1);
    chk("t4_play", int'(playing), 0);
    chk("t2_play_gap", gap_err, 0);
    chk("t2_both", both_n, 0);
    rec = 1'b0;
    pulse_restart();
    chk("t4_restart_dead", int'(dead), 0);
    chk("t4_restart_play", int'(playing), 0);

    // 3: ceiling clamp
    load(12);
    clr();
    pulse_flap();
    cyc_n(16);
    chk("t3_inc_n", inc_t.size(), 1);
    chk("t3_cnt", int'(cnt), 13);
    crash = 1'b1;
    cyc_n(1);
    crash = 1'b0;
    chk("t3_crash_dead", int'(dead), 1);
    pulse_restart();

    // 5: crash during rise, flap while dead
    load(5);
    clr();
    pulse_flap();
    wait_pulses(1'b0, 1, 20, "t5_inc_tmo");
    crash = 1'b1;
    cyc_n(1);
    crash = 1'b0;
    chk("t5_dead", int'(dead), 1);
    chk("t5_play", int'(playing), 0);
    cyc_n(20);
    chk("t5_inc_n", inc_t.size(), 1);
    pulse_flap();
    cyc_n(20);
    chk("t5_flap_dead", int'(dead), 1);
    chk("t5_pulses", inc_t.size() + dec_t.size(), 1);
    pulse_restart();

    // 6: held flap during fall, then reset mid-rise
    load(5);
    clr();
    pulse_flap();
    wait_pulses(1'b1, 1, 80, "t6_fall_tmo");
    clr();
    flap = 1'b1;
    cyc_n(40);
    flap = 1'b0;
    wait_pulses(1'b1, 3, 80, "t6_dec_tmo");
    cyc_n(2);
    chk("t6_inc_n", inc_t.size(), 3);
    chk("t6_cnt", int'(cnt), 7);
    if (inc_t.size() == 3 && dec_t.size() >= 2) begin
      chk("t6_hover_gap", dec_t[0] - inc_t[2], 20);
      chk("t6_dec_gap0", dec_t[1] - dec_t[0], 8);
    end
    clr();
    pulse_flap();
    wait_pulses(1'b0, 1, 20, "t6_rr_tmo");
    rst = 1'b0;
    #1;
    chk("t6_rst_inc", int'(inc), 0);
    chk("t6_rst_play", int'(playing), 0);
    cyc_n(3);
    rst = 1'b1;
    clr();
    cyc_n(30);
    chk("t6_post_inc", inc_t.size(), 0);
    chk("t6_post_dec", dec_t.size(), 0);
    chk("t6_post_play", int'(playing), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Sequences the bird height counter in the flappy-bird game.
- Turns the player's flap button into a timed series of one-cycle inc/dec pulses: a rise phase, a hover, then gravity-accelerated falling.
- Detects the ground/ceiling from the counter value, and handles crash and restart.
- Its inc/dec outputs drive the up/down height counter directly; its cnt input is that counter's output.

Parameters:
- b, 4, width of the height counter value.
- m, 14, counter modulus; legal heights 0..m-1, ceiling is m-1.
- TICK_CYCLES, 4, clocks per motion tick; must be >= 3.
- FLAP_STEPS, 3, inc pulses issued per flap.
- HOVER_TICKS, 2, ticks spent at the apex before falling.
- FALL_DLY0, 3, initial ticks between fall steps; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- flap  input  1  player button, synchronous level.
- crash  input  1  pipe-collision level, synchronous.
- restart  input  1  restart request, synchronous.
- cnt  input  b  current bird height from the counter.
- inc  output  1  one-cycle up pulse to the counter.
- dec  output  1  one-cycle down pulse to the counter.
- playing  output  1  high in RISE, HOVER and FALL.
- dead  output  1  high in DEAD.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: inc=0, dec=0, playing=0, dead=0.
  - State and registers: state=IDLE, prescaler=0, flap_q=0, all step counters=0.
  - Reset asserted mid-operation aborts immediately; no pulse is emitted after release until a new flap.
- Prescaler: free-running 0..TICK_CYCLES-1 in all states. tick=1 in the cycle the prescaler equals TICK_CYCLES-1.
- Flap edge detection:
  - flap_edge = flap & ~flap_q, where flap_q is the registered flap.
  - A held button gives exactly one edge.
- Pulse timing and sampling:
  - inc and dec are registered: high for exactly one cycle, the cycle after the qualifying tick.
  - inc and dec are never high together.
  - cnt is sampled in the tick cycle.
- Per-cycle priority: crash > flap_edge > tick action.
- IDLE:
  - No pulses.
  - flap_edge -> RISE, rise_cnt=FLAP_STEPS.
  - crash and restart are ignored.
- RISE:
  - On tick: if cnt != m-1, issue inc. rise_cnt decrements regardless, so the ceiling clamps without wrap-around.
  - When rise_cnt reaches 0 on a tick -> HOVER, hov_cnt=HOVER_TICKS.
  - flap_edge reloads rise_cnt=FLAP_STEPS and stays in RISE.
- HOVER:
  - No pulses.
  - hov_cnt decrements per tick; on reaching 0 -> FALL, fall_dly=FALL_DLY0, wait=FALL_DLY0.
  - flap_edge -> RISE, rise_cnt=FLAP_STEPS.
- FALL:
  - wait decrements per tick. When wait reaches 0 on a tick (a step):
    - if cnt==0: -> DEAD, no dec;
    - else: issue dec, fall_dly=max(fall_dly-1,1), wait=new fall_dly.
  - Resulting dec spacing: FALL_DLY0, FALL_DLY0-1, ..., 1, 1, ... ticks.
  - flap_edge -> RISE, rise_cnt=FLAP_STEPS; fall_dly restarts at FALL_DLY0 on the next FALL entry.
- Crash: crash=1 in RISE, HOVER or FALL -> DEAD on the next edge. Any pending inc/dec not yet registered is cancelled.
- DEAD:
  - dead=1, no pulses, flap ignored.
  - restart=1 -> IDLE.
  - crash while DEAD has no effect.
- Output decoding: playing and dead are decoded from the registered state; there is no combinational path from inputs to outputs.

Test Plan (TICK_CYCLES=4, FLAP_STEPS=3, HOVER_TICKS=2, FALL_DLY0=3, m=14):
1. Reset: hold rst=0 with random inputs -> inc=dec=playing=dead=0. Release with flap=0 -> no pulses for 100 cycles.
2. Flap from IDLE at cnt=5:
   - 3 inc pulses 4 cycles apart, cnt ends at 8.
   - Hover: 8 cycles without pulses.
   - Falling: dec pulses spaced 12, 8, 4, 4, ... cycles.
   - playing=1 throughout.
3. Ceiling: cnt=12, flap -> exactly one inc (cnt=13), then no inc for the remaining 2 rise ticks; cnt never wraps to 0.
4. Ground: fall to cnt=0 -> at the next step no dec, dead=1, playing=0. restart=1 -> IDLE, dead=0.
5. Crash during RISE after the first inc -> dead=1 next cycle, no further inc. Flap in DEAD -> no effect.
6. Flap held high for 40 cycles in FALL -> a single re-rise of 3 incs. The following fall restarts at 12-cycle spacing. Assert rst mid-rise -> pulses stop immediately, state IDLE.
